// File: rtl/pipe_pattern_pkg.sv
// Shared definitions for the pipe pattern generator and the Pipe In verifier.
// Both ends import this package so their seeds, taps and step rule are identical.
package pipe_pattern_pkg;

    localparam logic [63:0] SEED_LFSR  = 64'h0D0C0B0A04030201;
    localparam logic [63:0] SEED_COUNT = 64'h0000000100000001;

    localparam int TAP_A = 31;
    localparam int TAP_B = 21;
    localparam int TAP_C = 1;

    typedef enum logic {
        MODE_COUNT = 1'b0,
        MODE_LFSR  = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    function automatic logic [31:0] lfsr_step(input logic [31:0] h);
        return {h[30:0], h[TAP_A] ^ h[TAP_B] ^ h[TAP_C]};
    endfunction

    function automatic logic [63:0] seed_for(input mode_e m);
        return (m == MODE_LFSR) ? SEED_LFSR : SEED_COUNT;
    endfunction

endpackage

// File: rtl/pipe_pattern_step.sv
// Combinational next-state of the 64-bit pattern: two independent 32-bit halves,
// each either a 3-tap Fibonacci LFSR or a plain incrementer.
module pipe_pattern_step
    import pipe_pattern_pkg::*;
(
    input  mode_e       i_mode,
    input  logic [63:0] i_state,
    output logic [63:0] o_next
);

    always_comb begin
        o_next = i_state;
        case (i_mode)
            MODE_LFSR:  o_next = {lfsr_step(i_state[63:32]), lfsr_step(i_state[31:0])};
            MODE_COUNT: o_next = {i_state[63:32] + 32'd1, i_state[31:0] + 32'd1};
            default:    o_next = i_state;
        endcase
    end

endmodule

// File: rtl/pipe_in_verify.sv
// Scores a looped-back Pipe In word stream against the count/LFSR pattern.
// Two stages: S1 compares on the write cycle, S2 updates counters and first-error capture.
module pipe_in_verify
    import pipe_pattern_pkg::*;
#(
    parameter int ERR_W  = 16,
    parameter int WCNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_in_write,
    input  logic [15:0]       pipe_in_data,
    input  logic              mode,
    output logic [WCNT_W-1:0] word_count,
    output logic [ERR_W-1:0]  error_count,
    output logic              error_flag,
    output logic [WCNT_W-1:0] first_err_index,
    output logic [15:0]       first_err_exp,
    output logic [15:0]       first_err_got
);

    mode_e             r_mode_q;
    logic [63:0]       r_exp_state;
    logic [63:0]       w_next_state;
    logic              w_mismatch;

    logic              r_s1_valid;
    logic              r_s1_err;
    logic [15:0]       r_s1_exp;
    logic [15:0]       r_s1_got;

    state_e            r_state;
    logic [WCNT_W-1:0] r_word_count;
    logic [ERR_W-1:0]  r_error_count;
    logic              r_error_flag;
    logic [WCNT_W-1:0] r_first_err_index;
    logic [15:0]       r_first_err_exp;
    logic [15:0]       r_first_err_got;

    pipe_pattern_step u_step (
        .i_mode  (r_mode_q),
        .i_state (r_exp_state),
        .o_next  (w_next_state)
    );

    assign w_mismatch = (pipe_in_data != r_exp_state[15:0]);

    // Mode is latched only while reset is held; the seed uses the live input in that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode_q    <= mode_e'(mode);
            r_exp_state <= seed_for(mode_e'(mode));
        end else if (pipe_in_write) begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of block order.
            r_exp_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= pipe_in_write;
        end
    end

    // NOTE: payload flops carry no reset; they are only consumed when r_s1_valid is set.
    always_ff @(posedge clk) begin
        if (pipe_in_write) begin
            r_s1_err <= w_mismatch;
            r_s1_exp <= r_exp_state[15:0];
            r_s1_got <= pipe_in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= ST_IDLE;
            r_word_count      <= '0;
            r_error_count     <= '0;
            r_error_flag      <= 1'b0;
            r_first_err_index <= '0;
            r_first_err_exp   <= '0;
            r_first_err_got   <= '0;
        end else begin
            if (pipe_in_write && r_state == ST_IDLE) begin
                r_state <= ST_RUN;
            end
            if (r_s1_valid) begin
                r_word_count <= r_word_count + WCNT_W'(1);
                if (r_s1_err) begin
                    if (r_error_count != '1) begin
                        r_error_count <= r_error_count + ERR_W'(1);
                    end
                    // Capture uses the pre-increment count, so the first word is index 0.
                    if (r_state != ST_FAULT) begin
                        r_state           <= ST_FAULT;
                        r_error_flag      <= 1'b1;
                        r_first_err_index <= r_word_count;
                        r_first_err_exp   <= r_s1_exp;
                        r_first_err_got   <= r_s1_got;
                    end
                end
            end
        end
    end

    assign word_count      = r_word_count;
    assign error_count     = r_error_count;
    assign error_flag      = r_error_flag;
    assign first_err_index = r_first_err_index;
    assign first_err_exp   = r_first_err_exp;
    assign first_err_got   = r_first_err_got;

endmodule

// File: tb/tb_pipe_in_verify.sv
// Self-checking bench for pipe_in_verify: directed table, hand sequences and
// randomized streams scored against a word-level reference model.
module tb_pipe_in_verify;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_in_write;
    logic [15:0] pipe_in_data;
    logic        mode;

    logic [31:0] word_count, first_err_index;
    logic [15:0] error_count, first_err_exp, first_err_got;
    logic        error_flag;

    logic [31:0] word_count4, first_err_index4;
    logic [3:0]  error_count4;
    logic [15:0] first_err_exp4, first_err_got4;
    logic        error_flag4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_in_verify dut (
        .clk(clk), .reset(reset), .pipe_in_write(pipe_in_write),
        .pipe_in_data(pipe_in_data), .mode(mode),
        .word_count(word_count), .error_count(error_count), .error_flag(error_flag),
        .first_err_index(first_err_index), .first_err_exp(first_err_exp),
        .first_err_got(first_err_got)
    );

    pipe_in_verify #(.ERR_W(4), .WCNT_W(32)) dut4 (
        .clk(clk), .reset(reset), .pipe_in_write(pipe_in_write),
        .pipe_in_data(pipe_in_data), .mode(mode),
        .word_count(word_count4), .error_count(error_count4), .error_flag(error_flag4),
        .first_err_index(first_err_index4), .first_err_exp(first_err_exp4),
        .first_err_got(first_err_got4)
    );

    // Reference model: the expected stream is tracked by the low 32-bit half only,
    // since halves are independent and only bits [15:0] are ever compared.
    bit [31:0] m_lo;
    bit        m_mode;
    bit        m_pend, m_pend_bad;
    bit [15:0] m_pend_exp, m_pend_got;
    bit [31:0] m_wc;
    int        m_bad;
    bit        m_flag;
    bit [31:0] m_fidx;
    bit [15:0] m_fexp, m_fgot;

    function automatic bit [31:0] next_half(input bit lfsr, input bit [31:0] h);
        if (lfsr) return {h[30:0], h[31] ^ h[21] ^ h[1]};
        return h + 32'd1;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input bit wr, input bit md, input bit [15:0] data);
        if (rst) begin
            m_mode = md;
            m_lo   = md ? 32'h04030201 : 32'h00000001;
            m_pend = 1'b0;
            m_wc   = '0;
            m_bad  = 0;
            m_flag = 1'b0;
            m_fidx = '0;
            m_fexp = '0;
            m_fgot = '0;
        end else begin
            if (m_pend) begin
                if (m_pend_bad) begin
                    if (!m_flag) begin
                        m_flag = 1'b1;
                        m_fidx = m_wc;
                        m_fexp = m_pend_exp;
                        m_fgot = m_pend_got;
                    end
                    m_bad++;
                end
                m_wc++;
            end
            m_pend = wr;
            if (wr) begin
                m_pend_exp = m_lo[15:0];
                m_pend_got = data;
                m_pend_bad = (data != m_lo[15:0]);
                m_lo       = next_half(m_mode, m_lo);
            end
        end
    endtask

    task automatic compare_all();
        int sat16, sat4;
        sat16 = (m_bad > 65535) ? 65535 : m_bad;
        sat4  = (m_bad > 15) ? 15 : m_bad;
        check("word_count",       word_count,       m_wc);
        check("error_count",      error_count,      sat16);
        check("error_flag",       error_flag,       m_flag);
        check("first_err_index",  first_err_index,  m_fidx);
        check("first_err_exp",    first_err_exp,    m_fexp);
        check("first_err_got",    first_err_got,    m_fgot);
        check("w4_word_count",    word_count4,      m_wc);
        check("w4_error_count",   error_count4,     sat4);
        check("w4_error_flag",    error_flag4,      m_flag);
        check("w4_first_err_idx", first_err_index4, m_fidx);
        check("w4_first_err_exp", first_err_exp4,   m_fexp);
        check("w4_first_err_got", first_err_got4,   m_fgot);
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, then sample.
    task automatic step(input bit rst, input bit wr, input bit md, input bit [15:0] data);
        reset         = rst;
        pipe_in_write = wr;
        mode          = md;
        pipe_in_data  = wr ? data : 16'hxxxx;
        @(posedge clk);
        model_edge(rst, wr, md, data);
        #1;
        compare_all();
    endtask

    typedef struct {
        bit        rst;
        bit        wr;
        bit [15:0] data;
        bit [31:0] wc;
        bit [15:0] ec;
        bit        flag;
    } vec_t;

    initial begin
        vec_t tbl[8];
        bit   md;
        bit   bad;
        bit [15:0] d;

        reset = 1'b1; pipe_in_write = 1'b0; pipe_in_data = '0; mode = 1'b0;

        // Count mode: words 1,2,0xFFFF,4 then a second bad word; outputs lag by one edge.
        tbl[0] = '{1'b1, 1'b0, 16'h0000, 32'd0, 16'd0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 16'h0001, 32'd0, 16'd0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 16'h0002, 32'd1, 16'd0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 16'hFFFF, 32'd2, 16'd0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 16'h0004, 32'd3, 16'd1, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 16'h0000, 32'd4, 16'd1, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 16'h0099, 32'd4, 16'd1, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 16'h0000, 32'd5, 16'd2, 1'b1};
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].rst, tbl[i].wr, 1'b0, tbl[i].data);
            check($sformatf("tbl%0d_wc", i),   word_count,  tbl[i].wc);
            check($sformatf("tbl%0d_ec", i),   error_count, tbl[i].ec);
            check($sformatf("tbl%0d_flag", i), error_flag,  tbl[i].flag);
        end
        check("tbl_first_idx", first_err_index, 32'd2);
        check("tbl_first_exp", first_err_exp,   16'h0003);
        check("tbl_first_got", first_err_got,   16'hFFFF);

        // LFSR mode; mode pin toggled low mid-stream must be ignored.
        step(1'b1, 1'b0, 1'b1, 16'h0000);
        step(1'b0, 1'b1, 1'b1, 16'h0201);
        step(1'b0, 1'b1, 1'b0, 16'h0402);
        step(1'b0, 1'b1, 1'b0, 16'h0805);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        check("lfsr_wc",   word_count,  32'd3);
        check("lfsr_ec",   error_count, 16'd0);
        check("lfsr_flag", error_flag,  1'b0);

        // Saturation of the 4-bit error counter with 20 bad words.
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 16'hDEAD);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        check("sat_ec4",       error_count4,    4'hF);
        check("sat_ec16",      error_count,     16'd20);
        check("sat_wc",        word_count,      32'd20);
        check("sat_first_idx", first_err_index, 32'd0);
        check("sat_first_exp", first_err_exp,   16'h0001);

        // Reset in the same cycle as a write, and reset with a word still in S1.
        step(1'b0, 1'b1, 1'b0, 16'h1234);
        step(1'b1, 1'b1, 1'b0, 16'h5555);
        check("rstwr_wc",   word_count,  32'd0);
        check("rstwr_ec",   error_count, 16'd0);
        check("rstwr_flag", error_flag,  1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0001);
        step(1'b0, 1'b1, 1'b0, 16'h0002);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        check("restart_wc", word_count,  32'd2);
        check("restart_ec", error_count, 16'd0);
        step(1'b0, 1'b1, 1'b0, 16'hBEEF);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        check("flush_wc",   word_count, 32'd0);
        check("flush_flag", error_flag, 1'b0);

        // Randomized streams with 0-5 cycle gaps, random mode wiggle and rare resets.
        for (int r = 0; r < 6; r++) begin
            md = 1'($urandom_range(0, 1));
            step(1'b1, 1'b0, md, 16'h0000);
            for (int w = 0; w < 150; w++) begin
                int gap;
                gap = $urandom_range(0, 5);
                for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 16'h0000);
                if ($urandom_range(0, 199) == 0) begin
                    step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
                end
                bad = ($urandom_range(0, 7) == 0);
                d   = bad ? (m_lo[15:0] ^ 16'($urandom_range(1, 65535))) : m_lo[15:0];
                step(1'b0, 1'b1, 1'($urandom_range(0, 1)), d);
            end
            step(1'b0, 1'b0, 1'b0, 16'h0000);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
